// File: rtl/rx_decim_pkg.sv
// -----------------------------------------------------------------------------
// rx_decim_pkg
// Shared definitions for the multi-channel RX accumulate-and-dump decimator:
//   - bit positions of the fields inside the per-channel rate word
//     ([11:0] decimation factor R, [15:12] output shift S)
//   - the largest programmable decimation factor
//   - iq_t, the packed {q, i} result word at the default output width
// -----------------------------------------------------------------------------
package rx_decim_pkg;

    localparam int unsigned RATE_R_LSB = 0;
    localparam int unsigned RATE_R_MSB = 11;
    localparam int unsigned RATE_S_LSB = 12;
    localparam int unsigned RATE_S_MSB = 15;

    localparam int unsigned RATE_R_W = RATE_R_MSB - RATE_R_LSB + 1;
    localparam int unsigned RATE_S_W = RATE_S_MSB - RATE_S_LSB + 1;

    // Largest decimation factor the R field can express.
    localparam logic [RATE_R_W-1:0] RATE_R_MAX = {RATE_R_W{1'b1}};

    // Default per-component output width; channels with another OUT_W build
    // the same {q, i} layout locally at their own width.
    localparam int unsigned IQ_W = 32;

    typedef struct packed {
        logic signed [IQ_W-1:0] q;
        logic signed [IQ_W-1:0] i;
    } iq_t;

endpackage

// File: rtl/rx_decim_model_if.sv
// -----------------------------------------------------------------------------
// rx_decim_model_if
// Flat multi-channel bus of the RX decimator. Channel c occupies slice c of
// every vector.
//   rate_axis_tdata_i / rate_axis_tvalid_i : per-channel rate word load
//   rx_iq_axis_tdata_i / rx_iq_axis_tvalid_i : per-channel {Q, I} samples
//   axis_tdata_o / axis_tvalid_o / axis_tready_i : per-channel result stream
//   overflow_o : sticky per-channel drop flag
// Modports: master = traffic source / sink around the block, slave = the block.
// -----------------------------------------------------------------------------
interface rx_decim_model_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned RATE_W = 16
);
    import rx_decim_pkg::*;

    logic [NCH*RATE_W-1:0]  rate_axis_tdata_i;
    logic [NCH-1:0]         rate_axis_tvalid_i;
    logic [NCH*2*IN_W-1:0]  rx_iq_axis_tdata_i;
    logic [NCH-1:0]         rx_iq_axis_tvalid_i;
    logic [NCH*2*OUT_W-1:0] axis_tdata_o;
    logic [NCH-1:0]         axis_tvalid_o;
    logic [NCH-1:0]         axis_tready_i;
    logic [NCH-1:0]         overflow_o;

    modport master (
        output rate_axis_tdata_i, rate_axis_tvalid_i,
        output rx_iq_axis_tdata_i, rx_iq_axis_tvalid_i,
        output axis_tready_i,
        input  axis_tdata_o, axis_tvalid_o, overflow_o
    );

    modport slave (
        input  rate_axis_tdata_i, rate_axis_tvalid_i,
        input  rx_iq_axis_tdata_i, rx_iq_axis_tvalid_i,
        input  axis_tready_i,
        output axis_tdata_o, axis_tvalid_o, overflow_o
    );

endinterface

// File: rtl/rx_decim_chan.sv
// -----------------------------------------------------------------------------
// rx_decim_chan
// One independent RX channel: rate register, sample counter, I/Q
// accumulate-and-dump, output FIFO with registered head and sticky overflow.
// Optional feature macro: RX_DECIM_SHIFT_EN (arithmetic right shift of each
// pushed component by the S field of the rate word).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rate_word   : rate word, R in [11:0], S in [15:12]
//   rate_load   : loads rate_word, clears counter/accumulators/overflow
//   iq, iq_valid: {Q, I} signed sample and its valid
//   tdata, tvalid, tready : result stream (FIFO head)
//   overflow    : sticky, a result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module rx_decim_chan
    import rx_decim_pkg::*;
#(
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned RATE_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATE_W-1:0]  rate_word,
    input  logic               rate_load,
    input  logic [2*IN_W-1:0]  iq,
    input  logic               iq_valid,
    output logic [2*OUT_W-1:0] tdata,
    output logic               tvalid,
    input  logic               tready,
    output logic               overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EXT_W = OUT_W - IN_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic signed [OUT_W-1:0] q;
        logic signed [OUT_W-1:0] i;
    } chan_iq_t;

    logic [RATE_R_W-1:0]     r_r;
    logic [RATE_R_W-1:0]     cnt_r;
    logic signed [OUT_W-1:0] acc_i_r;
    logic signed [OUT_W-1:0] acc_q_r;
    chan_iq_t                mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        fill_r;
    chan_iq_t                head_r;
    logic                    valid_r;
    logic                    overflow_r;

    logic signed [OUT_W-1:0] samp_i_s;
    logic signed [OUT_W-1:0] samp_q_s;
    logic signed [OUT_W-1:0] sum_i_s;
    logic signed [OUT_W-1:0] sum_q_s;
    chan_iq_t                push_data_s;
    chan_iq_t                head_next_s;
    logic                    active_s;
    logic                    dump_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_acc_s;
    logic                    drop_s;
    logic [PTR_W-1:0]        rd_next_s;
    logic [CNT_W-1:0]        fill_next_s;
    logic                    unused_rate_s;

`ifdef RX_DECIM_SHIFT_EN
    logic [RATE_S_W-1:0]     s_r;
`endif

    // Only the R/S fields are stored; the rest of the rate word is don't-care.
    assign unused_rate_s = ^rate_word;

    // Datapath: sample extension, running sums, dump detect, FIFO bookkeeping
    always_comb begin
        samp_i_s = {{EXT_W{iq[IN_W-1]}}, iq[IN_W-1:0]};
        samp_q_s = {{EXT_W{iq[2*IN_W-1]}}, iq[2*IN_W-1:IN_W]};
        sum_i_s  = acc_i_r + samp_i_s;
        sum_q_s  = acc_q_r + samp_q_s;

        // A rate load on the same edge discards the sample and wins over a dump.
        active_s = iq_valid & ~rate_load & (r_r != {RATE_R_W{1'b0}});
        dump_s   = active_s & ((cnt_r + RATE_R_W'(1)) == r_r);

`ifdef RX_DECIM_SHIFT_EN
        push_data_s.i = sum_i_s >>> s_r;
        push_data_s.q = sum_q_s >>> s_r;
`else
        push_data_s.i = sum_i_s;
        push_data_s.q = sum_q_s;
`endif

        full_s      = (fill_r == FULL_CNT);
        pop_s       = valid_r & tready;
        // A full FIFO still accepts a push when a pop frees a slot this edge.
        push_acc_s  = dump_s & (~full_s | pop_s);
        drop_s      = dump_s & full_s & ~pop_s;
        rd_next_s   = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        fill_next_s = fill_r + CNT_W'(push_acc_s) - CNT_W'(pop_s);

        // The next head is either already in memory or being written right
        // now into the slot the read pointer will point at (empty FIFO case).
        if (push_acc_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Rate register, sample counter and accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r     <= {RATE_R_W{1'b0}};
            cnt_r   <= {RATE_R_W{1'b0}};
            acc_i_r <= {OUT_W{1'b0}};
            acc_q_r <= {OUT_W{1'b0}};
        end else if (rate_load) begin
            r_r     <= rate_word[RATE_R_MSB:RATE_R_LSB];
            cnt_r   <= {RATE_R_W{1'b0}};
            acc_i_r <= {OUT_W{1'b0}};
            acc_q_r <= {OUT_W{1'b0}};
        end else if (dump_s) begin
            cnt_r   <= {RATE_R_W{1'b0}};
            acc_i_r <= {OUT_W{1'b0}};
            acc_q_r <= {OUT_W{1'b0}};
        end else if (active_s) begin
            cnt_r   <= cnt_r + RATE_R_W'(1);
            acc_i_r <= sum_i_s;
            acc_q_r <= sum_q_s;
        end
    end

`ifdef RX_DECIM_SHIFT_EN
    // Output shift amount, loaded together with R
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= {RATE_S_W{1'b0}};
        end else if (rate_load) begin
            s_r <= rate_word[RATE_S_MSB:RATE_S_LSB];
        end
    end
`endif

    // FIFO storage write port (contents need no reset; fill level guards reads)
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, registered head/valid and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fill_r     <= {CNT_W{1'b0}};
            head_r     <= {(2*OUT_W){1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_next_s;
            fill_r   <= fill_next_s;
            head_r   <= head_next_s;
            valid_r  <= (fill_next_s != {CNT_W{1'b0}});
            if (rate_load) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign tdata    = head_r;
    assign tvalid   = valid_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/rx_decim_model.sv
// -----------------------------------------------------------------------------
// rx_decim_model
// Multi-channel RX accumulate-and-dump decimator with per-channel output FIFO,
// AXI-Stream backpressure and sticky overflow reporting. NCH independent
// rx_decim_chan instances; no cross-channel coupling.
// Optional feature macro: RX_DECIM_SHIFT_EN (per-channel output right shift).
// Ports:
//   clk : single clock
//   rst : synchronous, active-high reset
//   bus : rx_decim_model_if.slave carrying rate, sample, result and overflow
//         vectors, channel c in slice c
// -----------------------------------------------------------------------------
module rx_decim_model
    import rx_decim_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned RATE_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    rx_decim_model_if.slave  bus
);

    logic [2*OUT_W-1:0] tdata_s [NCH];
    logic [NCH-1:0]     tvalid_s;
    logic [NCH-1:0]     overflow_s;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        rx_decim_chan #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .RATE_W     (RATE_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .rate_word (bus.rate_axis_tdata_i[c*RATE_W +: RATE_W]),
            .rate_load (bus.rate_axis_tvalid_i[c]),
            .iq        (bus.rx_iq_axis_tdata_i[c*2*IN_W +: 2*IN_W]),
            .iq_valid  (bus.rx_iq_axis_tvalid_i[c]),
            .tdata     (tdata_s[c]),
            .tvalid    (tvalid_s[c]),
            .tready    (bus.axis_tready_i[c]),
            .overflow  (overflow_s[c])
        );
    end

    // Pack per-channel results onto the flat output bus
    always_comb begin
        bus.axis_tdata_o = {(NCH*2*OUT_W){1'b0}};
        for (int c = 0; c < NCH; c++) begin
            bus.axis_tdata_o[c*2*OUT_W +: 2*OUT_W] = tdata_s[c];
        end
    end

    assign bus.axis_tvalid_o = tvalid_s;
    assign bus.overflow_o    = overflow_s;

endmodule

// File: tb/tb_rx_decim_model.sv
// -----------------------------------------------------------------------------
// tb_rx_decim_model
// Directed and randomized stimulus for rx_decim_model (NCH=2, IN_W=16,
// OUT_W=32, FIFO_DEPTH=8). A per-channel reference keeps the running sample
// sum and a result queue; every cycle the DUT's valid/head/overflow are
// compared with it, plus fixed expected values at key scenario points.
// -----------------------------------------------------------------------------
module tb_rx_decim_model;
    import rx_decim_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    rx_decim_model_if #(.NCH(NCH), .IN_W(16), .OUT_W(32), .RATE_W(16)) bus ();

    rx_decim_model #(
        .NCH(NCH), .IN_W(16), .OUT_W(32), .RATE_W(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: rate fields, samples counted, running sums, results
    int          r_m   [NCH];
    int          s_m   [NCH];
    int          cnt_m [NCH];
    longint      acc_i [NCH];
    longint      acc_q [NCH];
    logic        ovf_m [NCH];
    logic [63:0] fq    [NCH][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference update for one clock edge, using the inputs present at it.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            logic               pop;
            logic               full;
            logic               push;
            logic signed [15:0] si;
            logic signed [15:0] sq;
            logic signed [31:0] ri;
            logic signed [31:0] rq;
            iq_t                res;
            push = 1'b0;
            res  = '0;
            if (rst) begin
                r_m[c] = 0; s_m[c] = 0; cnt_m[c] = 0;
                acc_i[c] = 0; acc_q[c] = 0; ovf_m[c] = 1'b0;
                fq[c].delete();
            end else begin
                pop  = (fq[c].size() > 0) && bus.axis_tready_i[c];
                full = (fq[c].size() == DEPTH);
                if (bus.rate_axis_tvalid_i[c]) begin
                    r_m[c]   = int'(bus.rate_axis_tdata_i[c*16 +: 12]);
                    s_m[c]   = int'(bus.rate_axis_tdata_i[c*16+12 +: 4]);
                    cnt_m[c] = 0; acc_i[c] = 0; acc_q[c] = 0;
                    ovf_m[c] = 1'b0;
                end else if (bus.rx_iq_axis_tvalid_i[c] && r_m[c] != 0) begin
                    si = bus.rx_iq_axis_tdata_i[c*32 +: 16];
                    sq = bus.rx_iq_axis_tdata_i[c*32+16 +: 16];
                    acc_i[c] += longint'(si);
                    acc_q[c] += longint'(sq);
                    cnt_m[c]++;
                    if (cnt_m[c] == r_m[c]) begin
                        ri = 32'(acc_i[c]);
                        rq = 32'(acc_q[c]);
`ifdef RX_DECIM_SHIFT_EN
                        ri = ri >>> s_m[c];
                        rq = rq >>> s_m[c];
`endif
                        res.i = ri;
                        res.q = rq;
                        if (!full || pop) push = 1'b1;
                        else ovf_m[c] = 1'b1;
                        cnt_m[c] = 0; acc_i[c] = 0; acc_q[c] = 0;
                    end
                end
                if (pop) void'(fq[c].pop_front());
                if (push) fq[c].push_back(res);
            end
        end
    endtask

    task automatic compare();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("tvalid[%0d]", c), 64'(bus.axis_tvalid_o[c]), 64'(fq[c].size() > 0));
            chk($sformatf("overflow[%0d]", c), 64'(bus.overflow_o[c]), 64'(ovf_m[c]));
            if (fq[c].size() > 0)
                chk($sformatf("tdata[%0d]", c), bus.axis_tdata_o[c*64 +: 64], fq[c][0]);
        end
    endtask

    // One clock: edge, reference update, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        bus.rate_axis_tvalid_i = 2'b00;
    endtask

    task automatic load(input int c, input logic [11:0] r, input logic [3:0] s);
        bus.rate_axis_tvalid_i[c] = 1'b1;
        bus.rate_axis_tdata_i[c*16 +: 16] = {s, r};
    endtask

    task automatic samp(input int c, input logic v, input logic [15:0] i, input logic [15:0] q);
        bus.rx_iq_axis_tvalid_i[c] = v;
        bus.rx_iq_axis_tdata_i[c*32 +: 32] = {q, i};
    endtask

    int n_out;
    logic [63:0] exp_w;

    initial begin
        rst = 1'b1;
        bus.rate_axis_tdata_i   = '0;
        bus.rate_axis_tvalid_i  = 2'b00;
        bus.rx_iq_axis_tdata_i  = '0;
        bus.rx_iq_axis_tvalid_i = 2'b00;
        bus.axis_tready_i       = 2'b00;
        @(negedge clk);
        step();
        step();
        chk("rst_tdata0", bus.axis_tdata_o[63:0], 64'd0);
        chk("rst_tdata1", bus.axis_tdata_o[127:64], 64'd0);
        chk("rst_tvalid", 64'(bus.axis_tvalid_o), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
        rst = 1'b0;

        // R = 1 pass-through, I = 100, Q = -100
        load(0, 12'd1, 4'd0);
        step();
        bus.axis_tready_i = 2'b11;
        samp(0, 1'b1, 16'd100, 16'hFF9C);
        step();
        chk("r1_first_valid", 64'(bus.axis_tvalid_o[0]), 64'd1);
        chk("r1_first_data", bus.axis_tdata_o[63:0], {32'hFFFF_FF9C, 32'd100});
        for (int k = 0; k < 6; k++) step();
        chk("r1_still_data", bus.axis_tdata_o[63:0], {32'hFFFF_FF9C, 32'd100});
        samp(0, 1'b0, 16'd0, 16'd0);
        step();

        // R = 4, I = 1..8 with the sink stalled: results 10 then 26
        load(0, 12'd4, 4'd0);
        bus.axis_tready_i = 2'b00;
        step();
        for (int k = 1; k <= 8; k++) begin
            samp(0, 1'b1, 16'(k), 16'd0);
            step();
        end
        samp(0, 1'b0, 16'd0, 16'd0);
        chk("r4_first", bus.axis_tdata_o[63:0], 64'd10);
        bus.axis_tready_i = 2'b01;
        step();
        chk("r4_second", bus.axis_tdata_o[63:0], 64'd26);
        step();
        chk("r4_drained", 64'(bus.axis_tvalid_o[0]), 64'd0);

        // Overflow: 40 samples at R = 4 with tready low
        bus.axis_tready_i = 2'b00;
        for (int k = 0; k < 40; k++) begin
            samp(0, 1'b1, 16'($urandom()), 16'($urandom()));
            step();
        end
        samp(0, 1'b0, 16'd0, 16'd0);
        chk("ovf_set", 64'(bus.overflow_o[0]), 64'd1);
        chk("ovf_tvalid", 64'(bus.axis_tvalid_o[0]), 64'd1);
        bus.axis_tready_i = 2'b01;
        n_out = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.axis_tvalid_o[0]) n_out++;
            step();
        end
        chk("ovf_drain_count", 64'(n_out), 64'd8);
        chk("ovf_sticky", 64'(bus.overflow_o[0]), 64'd1);

        // Reload R = 3 after two samples at R = 4; same-edge sample discarded
        load(0, 12'd4, 4'd0);
        step();
        chk("ovf_cleared", 64'(bus.overflow_o[0]), 64'd0);
        samp(0, 1'b1, 16'd5, 16'hFFFB); step();
        samp(0, 1'b1, 16'd7, 16'hFFF9); step();
        load(0, 12'd3, 4'd0);
        samp(0, 1'b1, 16'd1000, 16'd0); step();
        samp(0, 1'b1, 16'd2, 16'hFFFE); step();
        samp(0, 1'b1, 16'd3, 16'hFFFD); step();
        samp(0, 1'b1, 16'd4, 16'hFFFC); step();
        samp(0, 1'b0, 16'd0, 16'd0);
        chk("reload_data", bus.axis_tdata_o[63:0], {32'hFFFF_FFF7, 32'd9});
        step();

        // Shift: R = 4, S = 2, I = 8 constant
        load(0, 12'd4, 4'd2);
        step();
        for (int k = 0; k < 4; k++) begin
            samp(0, 1'b1, 16'd8, 16'd0);
            step();
        end
        samp(0, 1'b0, 16'd0, 16'd0);
`ifdef RX_DECIM_SHIFT_EN
        exp_w = 64'd8;
`else
        exp_w = 64'd32;
`endif
        chk("shift_data", bus.axis_tdata_o[63:0], exp_w);
        step();

        // Reset mid-stream: ch0 R = 2, ch1 R = 0
        load(0, 12'd2, 4'd0);
        load(1, 12'd0, 4'd0);
        bus.axis_tready_i = 2'b00;
        step();
        for (int k = 0; k < 5; k++) begin
            samp(0, 1'b1, 16'($urandom()), 16'($urandom()));
            samp(1, 1'b1, 16'($urandom()), 16'($urandom()));
            step();
        end
        chk("ch1_silent", 64'(bus.axis_tvalid_o[1]), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tdata", bus.axis_tdata_o[63:0], 64'd0);
        chk("mid_rst_tvalid", 64'(bus.axis_tvalid_o), 64'd0);
        chk("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
        bus.axis_tready_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            samp(0, 1'b1, 16'($urandom()), 16'($urandom()));
            step();
        end
        chk("ch0_silent_after_rst", 64'(bus.axis_tvalid_o[0]), 64'd0);

        // Randomized traffic on both channels
        for (int k = 0; k < 3000; k++) begin
            logic [11:0] rr;
            logic [3:0]  ss;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    rr = 12'($urandom_range(0, 5));
                    ss = 4'($urandom_range(0, 15));
                    load(c, rr, ss);
                end
                samp(c, 1'($urandom_range(0, 3) != 0), 16'($urandom()), 16'($urandom()));
                bus.axis_tready_i[c] = 1'($urandom_range(0, ((k / 500) % 3) + 1) != 0);
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
